// File: rtl/core_mem_responder_pkg.sv
// Shared types and constants for the core memory responder: FSM encoding,
// retire-status codes, the end-of-file instruction and address helpers.
package core_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_R   = 2'd0,
    STAT_I   = 2'd1,
    STAT_OVF = 2'd2,
    STAT_END = 2'd3
  } status_e;

  localparam logic [31:0] EOF_INST = 32'h2800_0000;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_EOF   = 6'h0A;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // Word index lies inside an array of 'words' entries (alignment ignored).
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
    return ({2'b00, addr[31:2]} < words);
  endfunction

  // Word-aligned and inside the array.
  function automatic logic word_ok(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] == 2'b00) && word_in_range(addr, words);
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-addressed RAM with synchronous write and either combinational or
// registered (resettable output, read-before-write) read.
module word_ram #(
  parameter int unsigned WORDS    = 256,
  parameter int unsigned DATA_W   = 32,
  parameter bit          REG_READ = 1'b0,
  localparam int unsigned AW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [DATA_W-1:0] r_rdata;
      // Same-edge write lands after this sample, so a colliding read sees old data.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else          r_rdata <= i_re ? r_mem[i_raddr] : '0;
      end
      assign o_rdata = r_rdata;
    end else begin : g_comb_read
      logic w_unused_rst;
      assign w_unused_rst = i_rst_n;
      assign o_rdata      = i_re ? r_mem[i_raddr] : '0;
    end
  endgenerate

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side harness for a small core: loads imem/dmem, releases the core,
// serves fetches and data accesses, and tracks retirement, completion and faults.
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld_valid,
  input  logic              i_ld_last,
  input  logic              i_ld_sel,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_i_addr,
  output logic [INST_W-1:0] o_i_inst,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  input  logic [1:0]        i_status,
  input  logic              i_status_valid,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_fault,
  output logic [1:0]        o_result,
  output logic [15:0]       o_retired
);

  localparam int unsigned IAW   = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW   = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cycles;
  logic               r_core_rst_n;
  logic               r_ld_ready;
  logic               r_done;
  logic               r_fault;
  logic [1:0]         r_result;
  logic [15:0]        r_retired;

  logic               w_run;
  logic               w_load;
  logic               w_i_ok;
  logic               w_d_ok;
  logic               w_d_rd_ok;
  logic               w_ld_ok;
  logic               w_end;
  logic               w_wdog;
  logic               w_fault;
  logic               w_im_we;
  logic               w_dm_we;
  logic [DAW-1:0]     w_dm_waddr;
  logic [DATA_W-1:0]  w_dm_wdata;
  logic [INST_W-1:0]  w_im_rdata;

  assign w_run     = (r_state == ST_RUN);
  assign w_load    = (r_state == ST_LOAD);
  assign w_i_ok    = word_ok(32'(i_i_addr), IMEM_WORDS);
  assign w_d_ok    = word_ok(32'(i_d_addr), DMEM_WORDS);
  assign w_d_rd_ok = word_in_range(32'(i_d_addr), DMEM_WORDS);
  assign w_ld_ok   = word_ok(32'(i_ld_addr), i_ld_sel ? DMEM_WORDS : IMEM_WORDS);

  // Overflow (2) and end (3) both have bit 1 set.
  assign w_end   = w_run & i_status_valid & i_status[1];
  assign w_wdog  = w_run & (r_cycles == CNT_W'(MAX_CYCLES - 1));
  assign w_fault = w_run & (~w_i_ok | (i_d_wen & ~w_d_ok) | w_wdog);

  // Load port owns dmem in LOAD; the core owns it in RUN.
  assign w_im_we    = w_load & i_ld_valid & ~i_ld_sel & w_ld_ok;
  assign w_dm_we    = (w_load & i_ld_valid & i_ld_sel & w_ld_ok) | (w_run & i_d_wen & w_d_ok);
  assign w_dm_waddr = w_run ? i_d_addr[DAW+1:2] : i_ld_addr[DAW+1:2];
  assign w_dm_wdata = w_run ? i_d_wdata : i_ld_data;

  word_ram #(
    .WORDS    (IMEM_WORDS),
    .DATA_W   (INST_W),
    .REG_READ (1'b0)
  ) u_imem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_im_we),
    .i_waddr (i_ld_addr[IAW+1:2]),
    .i_wdata (INST_W'(i_ld_data)),
    .i_re    (1'b1),
    .i_raddr (i_i_addr[IAW+1:2]),
    .o_rdata (w_im_rdata)
  );

  word_ram #(
    .WORDS    (DMEM_WORDS),
    .DATA_W   (DATA_W),
    .REG_READ (1'b1)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_dm_we),
    .i_waddr (w_dm_waddr),
    .i_wdata (w_dm_wdata),
    .i_re    (w_d_rd_ok),
    .i_raddr (i_d_addr[DAW+1:2]),
    .o_rdata (o_d_rdata)
  );

  assign o_i_inst = w_i_ok ? w_im_rdata : INST_W'(EOF_INST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_LOAD;
    else          r_state <= w_next;
  end

  // Completion takes priority over any fault raised in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: if (i_ld_valid && i_ld_last) w_next = ST_RUN;
      ST_RUN: begin
        if (w_end)        w_next = ST_DONE;
        else if (w_fault) w_next = ST_FAULT;
      end
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycles     <= '0;
      r_core_rst_n <= 1'b0;
      r_ld_ready   <= 1'b1;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_result     <= '0;
      r_retired    <= '0;
    end else begin
      r_core_rst_n <= (w_next == ST_RUN);
      r_ld_ready   <= (w_next == ST_LOAD);
      r_done       <= (w_next == ST_DONE);
      r_fault      <= (w_next == ST_FAULT);
      if (w_run) r_cycles <= r_cycles + CNT_W'(1);
      if (w_run && i_status_valid && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
      if (w_end) r_result <= i_status;
    end
  end

  assign o_core_rst_n = r_core_rst_n;
  assign o_ld_ready   = r_ld_ready;
  assign o_done       = r_done;
  assign o_fault      = r_fault;
  assign o_result     = r_result;
  assign o_retired    = r_retired;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed-plus-random bench for core_mem_responder with a word-array model
// of dmem and expected values taken from the block's behavioural rules.
module tb_core_mem_responder;
  import core_mem_responder_pkg::*;

  localparam int unsigned IW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_last, ld_sel;
  logic [31:0] ld_addr, ld_data;
  logic        ld_ready;
  logic [31:0] i_addr, inst;
  logic        d_wen;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  status;
  logic        status_valid;
  logic        core_rst_n, done, fault;
  logic [1:0]  result;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dmem_m [DW];
  logic [31:0] imem_m [3];

  always #5 clk = ~clk;

  core_mem_responder #(
    .IMEM_WORDS (IW),
    .DMEM_WORDS (DW),
    .MAX_CYCLES (MC)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ld_valid     (ld_valid),
    .i_ld_last      (ld_last),
    .i_ld_sel       (ld_sel),
    .i_ld_addr      (ld_addr),
    .i_ld_data      (ld_data),
    .o_ld_ready     (ld_ready),
    .i_i_addr       (i_addr),
    .o_i_inst       (inst),
    .i_d_wen        (d_wen),
    .i_d_addr       (d_addr),
    .i_d_wdata      (d_wdata),
    .o_d_rdata      (d_rdata),
    .i_status       (status),
    .i_status_valid (status_valid),
    .o_core_rst_n   (core_rst_n),
    .o_done         (done),
    .o_fault        (fault),
    .o_result       (result),
    .o_retired      (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_last = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    i_addr = 32'h8; d_wen = 0; d_addr = 0; d_wdata = 0;
    status = 0; status_valid = 0;
  endtask

  task automatic load(input logic sel, input logic [31:0] addr, input logic [31:0] data,
                      input logic last);
    ld_valid = 1; ld_sel = sel; ld_addr = addr; ld_data = data; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // Out-of-range dmem word with last: nothing written, just enters RUN.
  task automatic go_run();
    load(1'b1, 32'h100, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic pulse_status(input logic [1:0] s);
    status_valid = 1; status = s;
    tick();
    status_valid = 0;
  endtask

  initial begin
    logic [31:0] addr_v;
    logic [31:0] data_v;
    int          w;
    int          cnt;
    logic        we;

    idle();
    rst_n = 0;
    tick(); tick();
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_ld_ready",   32'(ld_ready),   32'd1);
    chk("rst_d_rdata",    d_rdata,         32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_fault",      32'(fault),      32'd0);
    chk("rst_result",     32'(result),     32'd0);
    chk("rst_retired",    32'(retired),    32'd0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 16; i++) begin
      dmem_m[i] = (i == 8) ? 32'h5 : $urandom;
      load(1'b1, 32'(i * 4), dmem_m[i], 1'b0);
    end
    load(1'b1, 32'h6,   32'hBAD0_0001, 1'b0);
    load(1'b1, 32'h100, 32'hBAD0_0002, 1'b0);
    chk("load_ready_held", 32'(ld_ready),   32'd1);
    chk("load_core_held",  32'(core_rst_n), 32'd0);

    for (int i = 0; i < 3; i++) begin
      imem_m[i] = $urandom;
      load(1'b0, 32'(i * 4), imem_m[i], i == 2);
    end
    chk("run_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("run_ld_ready",   32'(ld_ready),   32'd0);
    chk("fetch_8",        inst,            imem_m[2]);
    i_addr = 32'h0; #1;
    chk("fetch_0",        inst,            imem_m[0]);
    i_addr = 32'h4; #1;
    chk("fetch_4",        inst,            imem_m[1]);
    i_addr = 32'h8;

    d_wen = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick();
    d_wen = 0;
    chk("wr_old_rdata", d_rdata, dmem_m[4]);
    dmem_m[4] = 32'hDEAD_BEEF;
    tick();
    chk("rd_deadbeef", d_rdata, 32'hDEAD_BEEF);

    d_wen = 1; d_addr = 32'h20; d_wdata = 32'h1;
    tick();
    d_wen = 0;
    chk("rw_same_old", d_rdata, 32'h5);
    dmem_m[8] = 32'h1;
    tick();
    chk("rw_same_new", d_rdata, 32'h1);

    for (int k = 0; k < 3; k++) begin
      w = int'($urandom_range(15, 0));
      we = 1'($urandom_range(1, 0));
      data_v = $urandom;
      d_wen = we; d_addr = 32'(w * 4); d_wdata = data_v;
      tick();
      d_wen = 0;
      chk("rand_rd", d_rdata, dmem_m[w]);
      if (we) dmem_m[w] = data_v;
    end

    d_addr = 32'h100;
    tick();
    chk("rd_out_of_range", d_rdata, 32'd0);
    d_addr = 32'h4;
    tick();
    chk("misaligned_load_dropped", d_rdata, dmem_m[1]);

    pulse_status(2'd0); pulse_status(2'd1); pulse_status(2'd1);
    pulse_status(2'd0); pulse_status(2'd3);
    chk("end_done",       32'(done),       32'd1);
    chk("end_result",     32'(result),     32'd3);
    chk("end_retired",    32'(retired),    32'd5);
    chk("end_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("end_fault",      32'(fault),      32'd0);
    chk("end_ld_ready",   32'(ld_ready),   32'd0);

    status_valid = 1; status = 2'd2;
    d_wen = 1; d_addr = 32'h10; d_wdata = 32'h0;
    tick();
    status_valid = 0; d_wen = 0;
    tick();
    chk("done_retired_hold", 32'(retired), 32'd5);
    chk("done_result_hold",  32'(result),  32'd3);
    chk("done_write_ignored", d_rdata,     32'hDEAD_BEEF);

    do_reset();
    go_run();
    chk("s2_core_rst_n", 32'(core_rst_n), 32'd1);
    pulse_status(2'd0); pulse_status(2'd1);
    chk("s2_retired", 32'(retired), 32'd2);
    #2 rst_n = 0;
    #1;
    chk("async_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("async_retired",    32'(retired),    32'd0);
    chk("async_ld_ready",   32'(ld_ready),   32'd1);
    tick();
    rst_n = 1;
    tick();

    go_run();
    d_wen = 1; d_addr = 32'h6; d_wdata = 32'hFFFF_FFFF;
    tick();
    d_wen = 0;
    chk("misalign_wr_fault",  32'(fault),      32'd1);
    chk("misalign_wr_done",   32'(done),       32'd0);
    chk("misalign_wr_result", 32'(result),     32'd0);
    chk("misalign_wr_core",   32'(core_rst_n), 32'd0);
    d_addr = 32'h4;
    tick();
    chk("misalign_wr_suppressed", d_rdata, dmem_m[1]);

    do_reset();
    go_run();
    status_valid = 1; status = 2'd2;
    d_wen = 1; d_addr = 32'h6;
    tick();
    status_valid = 0; d_wen = 0;
    chk("done_wins_done",   32'(done),   32'd1);
    chk("done_wins_fault",  32'(fault),  32'd0);
    chk("done_wins_result", 32'(result), 32'd2);

    do_reset();
    go_run();
    i_addr = 32'h100; #1;
    chk("fetch_oor_eof", inst, EOF_INST);
    i_addr = 32'h2; #1;
    chk("fetch_misalign_eof", inst, EOF_INST);
    tick();
    chk("fetch_fault", 32'(fault), 32'd1);
    i_addr = 32'h8;

    do_reset();
    go_run();
    cnt = 0;
    while (!fault && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("wdog_cycles", 32'(cnt),    32'(MC));
    chk("wdog_result", 32'(result), 32'd0);
    chk("wdog_done",   32'(done),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 Parameters (name, default, meaning): IMEM_WORDS, 256, instruction words; DMEM_WORDS, 256, data words; MAX_CYCLES, 4096, RUN-state watchdog limit; ADDR_W/INST_W/DATA_W, 32, bus widths.
REQ-002 Ports (name direction width meaning): i_clk in 1 clock; i_rst_n in 1 async active-low reset.
REQ-003 i_ld_valid in 1, i_ld_last in 1, i_ld_sel in 1 (0 imem, 1 dmem), i_ld_addr in 32 byte address, i_ld_data in 32: program/data load port; o_ld_ready out 1.
REQ-004 i_i_addr in 32 fetch address; o_i_inst out 32 fetched instruction.
REQ-005 i_d_wen in 1, i_d_addr in 32, i_d_wdata in 32: core data request; o_d_rdata out 32 read data.
REQ-006 i_status in 2, i_status_valid in 1: core retire status (0 R-type, 1 I-type, 2 overflow, 3 end).
REQ-007 o_core_rst_n out 1 core reset; o_done out 1; o_fault out 1; o_result out 2 final status; o_retired out 16 retired-instruction count.
REQ-008 The block SHALL use one clock, i_clk, and an asynchronous active-low reset, i_rst_n.

Function
REQ-009 FSM states LOAD, RUN, DONE, FAULT; reset state LOAD.
REQ-010 LOAD: o_ld_ready=1; each cycle with i_ld_valid writes i_ld_data to the array chosen by i_ld_sel at word index i_ld_addr[.. :2]; out-of-range or misaligned load words SHALL be dropped silently.
REQ-011 i_ld_valid with i_ld_last: the word is written and state becomes RUN next cycle.
REQ-012 o_core_rst_n SHALL be a registered output, 0 in LOAD/DONE/FAULT, 1 in RUN (core released on first RUN cycle).
REQ-013 Fetch: o_i_inst = imem[i_i_addr word index] combinationally (zero latency); misaligned or out-of-range i_i_addr returns 32'h2800_0000 (EOF) and, in RUN, enters FAULT next cycle.
REQ-014 Data read: o_d_rdata SHALL be registered, = dmem[i_d_addr word index] one cycle after the address is presented; out-of-range reads return 0.
REQ-015 Data write: in RUN with i_d_wen=1, dmem written at posedge; read and write to same word in same cycle returns the old value next cycle.
REQ-016 i_d_wen with misaligned or out-of-range i_d_addr in RUN: write suppressed, FAULT next cycle.
REQ-017 Status: in RUN, each i_status_valid increments o_retired (saturates at 16'hFFFF); status 2 or 3 latches o_result and enters DONE next cycle with o_done=1.
REQ-018 Watchdog: RUN cycle counter reaching MAX_CYCLES without DONE enters FAULT; o_fault=1, o_result=0.
REQ-019 Fault and done on the same cycle: DONE wins.
REQ-020 DONE and FAULT are terminal until reset; ld port, status and data writes ignored; o_ld_ready=0.
REQ-021 i_status_valid or i_d_wen outside RUN SHALL be ignored.

Reset
REQ-022 Reset values: state LOAD, o_core_rst_n 0, o_ld_ready 1, o_d_rdata 0, o_done 0, o_fault 0, o_result 0, o_retired 0, cycle counter 0.
REQ-023 Memory arrays SHALL NOT be reset; contents undefined until loaded.
REQ-024 Reset asserted mid-RUN returns to LOAD immediately and drives o_core_rst_n low asynchronously.

Structure
REQ-025 Shared package: FSM state encoding, status codes (R 0, I 1, OVF 2, END 3), EOF instruction constant, opcode constants.
REQ-026 One sub-module, word_ram (sync write, configurable comb/registered read), instantiated for imem and dmem.

Verification
REQ-027 Load 3 imem words, last asserted on third -> o_core_rst_n high 1 cycle later, o_i_inst at addr 8 equals third word.
REQ-028 RUN, write 32'hDEAD_BEEF to 0x10 then read 0x10 -> o_d_rdata = 32'hDEAD_BEEF one cycle after read address.
REQ-029 Same-cycle write 32'h1 and read of word 0x20 holding 32'h5 -> next-cycle o_d_rdata = 32'h5.
REQ-030 Five status pulses (0,1,1,0,3) -> o_retired=5, o_result=3, o_done=1, o_core_rst_n=0.
REQ-031 i_d_wen with i_d_addr 0x6 -> no write, o_fault=1 next cycle; MAX_CYCLES=16 with no END -> o_fault=1 at cycle 16.
REQ-032 Reset pulse during RUN -> o_core_rst_n low immediately, state LOAD, o_retired=0.
